jt12_op_seq: RTL

Slot sequencer and per-channel configuration holder for the FM operator datapath. Runs the operator-slot counter and emits the one-hot slot-group strobes (s1/s3/s2/s4 enters) and the frame marker `zero`. Produces the per-slot modulation source selects (xuse_*/yuse_*) from each channel's algorithm, plus the stage-II feedback level. Holds algorithm/feedback per channel and commits CPU writes only at channel-frame boundaries.

---
 rtl/jt12_seq_pkg.sv | 37 +++
 rtl/jt12_op_cfg.sv | 68 ++++++
 rtl/jt12_op_seq.sv | 101 ++++++++++
 3 files changed

// File: rtl/jt12_seq_pkg.sv
// Shared definitions for the FM operator slot sequencer: slot-group codes,
// operand-select field layout and the algorithm-to-select table.
package jt12_seq_pkg;

  typedef enum logic [1:0] {
    GRP_S1 = 2'd0,
    GRP_S3 = 2'd1,
    GRP_S2 = 2'd2,
    GRP_S4 = 2'd3
  } grp_e;

  typedef struct packed {
    logic xusePrevprev1;
    logic xusePrev2;
    logic xuseInternal;
    logic yusePrev1;
    logic yusePrev2;
    logic yuseInternal;
  } sel_t;

  // Rows are algorithms, columns are groups in processing order S1,S3,S2,S4
  localparam logic [5:0] SEL [8][4] = '{
    '{6'b100100, 6'b000100, 6'b000100, 6'b000100},
    '{6'b100100, 6'b000000, 6'b100100, 6'b000100},
    '{6'b100100, 6'b000000, 6'b000100, 6'b010100},
    '{6'b100100, 6'b000100, 6'b000000, 6'b001100},
    '{6'b100100, 6'b000100, 6'b000000, 6'b000100},
    '{6'b100100, 6'b000100, 6'b000010, 6'b000001},
    '{6'b100100, 6'b000100, 6'b000000, 6'b000000},
    '{6'b100100, 6'b000000, 6'b000000, 6'b000000}
  };

  function automatic int slots_per_frame(input int n);
    return 4 * n;
  endfunction

endpackage

// File: rtl/jt12_op_cfg.sv
// Per-channel algorithm/feedback store. CPU writes park in a pending entry
// and only become visible when that channel's S1 slot is decoded.
module jt12_op_cfg
  import jt12_seq_pkg::*;
#(
  parameter int num_ch = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       cfg_we,
  input  logic [2:0] cfg_ch,
  input  logic [2:0] cfg_alg,
  input  logic [2:0] cfg_fb,
  input  logic [2:0] i_slotCh,
  input  logic       i_isS1,
  input  logic [2:0] i_fbCh,
  output logic [2:0] o_alg,
  output logic [2:0] o_fb,
  output logic       o_ack,
  output logic [2:0] o_ackCh
);

  logic [2:0]        r_pendAlg [num_ch];
  logic [2:0]        r_pendFb  [num_ch];
  logic [2:0]        r_alg     [num_ch];
  logic [2:0]        r_fb      [num_ch];
  logic [num_ch-1:0] r_pendV;

  logic w_wrValid;
  logic w_commit;

  assign w_wrValid = cfg_we && (cfg_ch < 3'(num_ch));
  assign w_commit  = i_isS1 && r_pendV[i_slotCh];

  // The committing slot already sees its new algorithm
  assign o_alg = w_commit ? r_pendAlg[i_slotCh] : r_alg[i_slotCh];
  assign o_fb  = r_fb[i_fbCh];

  // A write landing on its own channel's commit edge re-arms pending
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < num_ch; i++) begin
        r_pendAlg[i] <= '0;
        r_pendFb[i]  <= '0;
        r_alg[i]     <= '0;
        r_fb[i]      <= '0;
      end
      r_pendV <= '0;
      o_ack   <= 1'b0;
      o_ackCh <= '0;
    end else if (clk_en) begin
      o_ack   <= w_commit;
      o_ackCh <= w_commit ? i_slotCh : 3'd0;
      if (w_commit) begin
        r_alg[i_slotCh]   <= r_pendAlg[i_slotCh];
        r_fb[i_slotCh]    <= r_pendFb[i_slotCh];
        r_pendV[i_slotCh] <= 1'b0;
      end
      if (w_wrValid) begin
        r_pendAlg[cfg_ch] <= cfg_alg;
        r_pendFb[cfg_ch]  <= cfg_fb;
        r_pendV[cfg_ch]   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/jt12_op_seq.sv
// Operator slot sequencer: walks the 4*num_ch slot frame and registers the
// group strobes, operand selects and stage-II feedback for every slot.
module jt12_op_seq
  import jt12_seq_pkg::*;
#(
  parameter int num_ch = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       cfg_we,
  input  logic [2:0] cfg_ch,
  input  logic [2:0] cfg_alg,
  input  logic [2:0] cfg_fb,
  output logic       cfg_ack,
  output logic [2:0] cfg_ack_ch,
  output logic       s1_enters,
  output logic       s3_enters,
  output logic       s2_enters,
  output logic       s4_enters,
  output logic       zero,
  output logic [2:0] slot_ch,
  output logic       xuse_prevprev1,
  output logic       xuse_prev2,
  output logic       xuse_internal,
  output logic       yuse_prev1,
  output logic       yuse_prev2,
  output logic       yuse_internal,
  output logic [2:0] fb_II
);

  localparam int SLOTS = slots_per_frame(num_ch);

  logic [4:0] r_cnt;
  grp_e       w_grp;
  logic [2:0] w_ch;
  logic       w_isS1;
  logic [2:0] w_alg;
  logic [2:0] w_fbPrev;
  sel_t       w_sel;

  assign w_grp  = grp_e'(2'(r_cnt / 5'(num_ch)));
  assign w_ch   = 3'(r_cnt % 5'(num_ch));
  assign w_isS1 = (w_grp == GRP_S1);
  assign w_sel  = sel_t'(SEL[w_alg][w_grp]);

  // Feedback read port follows the registered slot so fb_II lags S1 by one
  jt12_op_cfg #(
    .num_ch(num_ch)
  ) u_cfg (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_alg (cfg_alg),
    .cfg_fb  (cfg_fb),
    .i_slotCh(w_ch),
    .i_isS1  (w_isS1),
    .i_fbCh  (slot_ch),
    .o_alg   (w_alg),
    .o_fb    (w_fbPrev),
    .o_ack   (cfg_ack),
    .o_ackCh (cfg_ack_ch)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      s1_enters      <= 1'b0;
      s3_enters      <= 1'b0;
      s2_enters      <= 1'b0;
      s4_enters      <= 1'b0;
      zero           <= 1'b0;
      slot_ch        <= '0;
      xuse_prevprev1 <= 1'b0;
      xuse_prev2     <= 1'b0;
      xuse_internal  <= 1'b0;
      yuse_prev1     <= 1'b0;
      yuse_prev2     <= 1'b0;
      yuse_internal  <= 1'b0;
      fb_II          <= '0;
    end else if (clk_en) begin
      r_cnt          <= (r_cnt == 5'(SLOTS - 1)) ? 5'd0 : r_cnt + 5'd1;
      s1_enters      <= (w_grp == GRP_S1);
      s3_enters      <= (w_grp == GRP_S3);
      s2_enters      <= (w_grp == GRP_S2);
      s4_enters      <= (w_grp == GRP_S4);
      zero           <= (r_cnt == 5'd0);
      slot_ch        <= w_ch;
      xuse_prevprev1 <= w_sel.xusePrevprev1;
      xuse_prev2     <= w_sel.xusePrev2;
      xuse_internal  <= w_sel.xuseInternal;
      yuse_prev1     <= w_sel.yusePrev1;
      yuse_prev2     <= w_sel.yusePrev2;
      yuse_internal  <= w_sel.yuseInternal;
      fb_II          <= s1_enters ? w_fbPrev : 3'd0;
    end
  end

endmodule
